// File: rtl/seg7_mux_if.sv
// seg7_mux_if: bus select, direction and word address of the core data bus.
interface seg7_mux_if;
  logic        enable;
  logic        rw;
  logic [31:0] addr;
  modport master (output enable, rw, addr);
  modport slave  (input enable, rw, addr);
endinterface

// File: rtl/seg7_mux.sv
// seg7_mux: memory-mapped N-digit multiplexed 7-segment controller with PWM brightness.
module seg7_mux #(
  parameter logic [31:0] BASE      = 32'h100,
  parameter int          DIGITS    = 4,
  parameter int          SCAN_LOG2 = 14,
  parameter int          PWM_BITS  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  seg7_mux_if.slave         bus,
  inout  wire  [31:0]       data,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);
  localparam int          IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [31:0] VMASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
  localparam logic [7:0]  DMASK = 8'((16'd1 << DIGITS) - 16'd1);
  localparam logic [63:0] RMASK = 64'((128'd1 << (8 * DIGITS)) - 128'd1);
  logic [31:0]          value_q;
  logic [7:0]           dp_q, blank_q;
  logic                 raw_mode_q, lz_q;
  logic [63:0]          raw_q;
  logic [PWM_BITS-1:0]  bright_q;
  logic [SCAN_LOG2-1:0] div_q;
  logic [IW-1:0]        idx_q;
  logic [31:0]          off, rdata;
  logic                 in_range, wr, rd;
  logic [3:0]           nib;
  logic [7:0]           raw_byte;
  logic [6:0]           glyph;
  logic [PWM_BITS-1:0]  ph;
  logic                 dp_k, lz_dark, lit;
  logic [7:0]           seg_d;
  logic [DIGITS-1:0]    an_d;
  // addresses below BASE wrap to a large offset, so one compare covers both bounds
  assign off      = bus.addr - BASE;
  assign in_range = off < 32'd5;
  assign wr       = bus.enable && bus.rw && in_range;
  assign rd       = bus.enable && !bus.rw && in_range;
  assign data     = rd ? rdata : 'z;
  always_comb begin
    rdata = off == 32'd0 ? value_q :
            off == 32'd1 ? {14'd0, lz_q, raw_mode_q, blank_q, dp_q} :
            off == 32'd2 ? raw_q[31:0] :
            off == 32'd3 ? raw_q[63:32] : 32'(bright_q);
  end
  always_comb begin
    nib = value_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end
  // unstored upper nibbles are zero, so a right shift tests nibbles k..DIGITS-1
  always_comb begin
    raw_byte = raw_q[{idx_q, 3'b000} +: 8];
    dp_k     = dp_q[idx_q];
    lz_dark  = lz_q && !raw_mode_q && idx_q != '0 && (value_q >> {idx_q, 2'b00}) == 32'd0;
    ph       = div_q[SCAN_LOG2-1 -: PWM_BITS];
    lit      = div_q != '0 && ph <= bright_q && !blank_q[idx_q] && !lz_dark;
    seg_d    = !lit ? 8'hFF :
               raw_mode_q ? ~{raw_byte[7] | dp_k, raw_byte[6:0]} : ~{dp_k, glyph};
    an_d     = lit ? ~(DIGITS'(1) << idx_q) : '1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q    <= '0;
      dp_q       <= '0;
      blank_q    <= '0;
      raw_mode_q <= 1'b0;
      lz_q       <= 1'b0;
      raw_q      <= '0;
      bright_q   <= '1;
      div_q      <= '0;
      idx_q      <= '0;
      seg        <= 8'hFF;
      an         <= '1;
    end else begin
      div_q <= div_q + 1'b1;
      if (&div_q) idx_q <= idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
      seg <= seg_d;
      an  <= an_d;
      if (wr && off == 32'd0) value_q <= data & VMASK;
      if (wr && off == 32'd1) begin
        dp_q       <= data[7:0] & DMASK;
        blank_q    <= data[15:8] & DMASK;
        raw_mode_q <= data[16];
        lz_q       <= data[17];
      end
      if (wr && off == 32'd2) raw_q[31:0]  <= data & RMASK[31:0];
      if (wr && off == 32'd3) raw_q[63:32] <= data & RMASK[63:32];
      if (wr && off == 32'd4) bright_q     <= data[PWM_BITS-1:0];
    end
  end
endmodule

// File: tb/tb_seg7_mux.sv
// tb_seg7_mux: directed checks of registers, scan, PWM, blanking and reset of seg7_mux.
module tb_seg7_mux;
  localparam logic [31:0] BASE = 32'h100;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       drv = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rv;
  wire  [31:0] data;
  logic [7:0] seg;
  logic [3:0] an;
  int checks = 0;
  int errors = 0;
  int lit_cnt [4];
  logic [7:0] seg_seen [4];
  int multi;
  seg7_mux_if bus ();
  seg7_mux #(.BASE(BASE), .DIGITS(4), .SCAN_LOG2(6), .PWM_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .data(data), .seg(seg), .an(an)
  );
  assign data = drv ? wdata : 'z;
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (data[g]);
  end
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.enable = 1'b1; bus.rw = 1'b1; bus.addr = a; wdata = d; drv = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0; bus.rw = 1'b0; drv = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.enable = 1'b1; bus.rw = 1'b0; bus.addr = a;
    #1 v = data;
    bus.enable = 1'b0;
  endtask
  // 256 consecutive cycles visit every (digit, divider) pair exactly once
  task automatic scan();
    logic [3:0] m;
    bit found;
    for (int k = 0; k < 4; k++) begin
      lit_cnt[k] = 0;
      seg_seen[k] = 8'hFF;
    end
    multi = 0;
    repeat (256) begin
      @(negedge clk);
      if (an != 4'hF) begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          m = 4'b1 << k;
          if (an == ~m) begin
            lit_cnt[k]++;
            seg_seen[k] = seg;
            found = 1;
          end
        end
        if (!found) multi++;
      end
    end
  endtask
  initial begin
    int n;
    bus.enable = 1'b0; bus.rw = 1'b0; bus.addr = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    reset_n = 1'b1;
    rd(BASE, rv);     check("reset_value", rv, 32'h0);
    rd(BASE + 4, rv); check("reset_bright", rv, 32'hF);
    rd(BASE + 1, rv); check("reset_ctrl", rv, 32'h0);
    // hex display
    wr(BASE, 32'h1234);
    rd(BASE, rv); check("value_rb", rv, 32'h1234);
    scan();
    check("hex_d0", 32'(seg_seen[0]), 32'h99);
    check("hex_d1", 32'(seg_seen[1]), 32'hB0);
    check("hex_d2", 32'(seg_seen[2]), 32'hA4);
    check("hex_d3", 32'(seg_seen[3]), 32'hF9);
    for (int k = 0; k < 4; k++) check($sformatf("full_duty_d%0d", k), 32'(lit_cnt[k]), 32'd63);
    check("one_cold", 32'(multi), 32'd0);
    // leading-zero suppression
    wr(BASE + 1, 32'h20000);
    wr(BASE, 32'h0007);
    scan();
    check("lz7_d0", 32'(seg_seen[0]), 32'hF8);
    check("lz7_lit0", 32'(lit_cnt[0]), 32'd63);
    check("lz7_dark", 32'(lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 32'd0);
    wr(BASE, 32'h0);
    scan();
    check("lz0_d0", 32'(seg_seen[0]), 32'hC0);
    check("lz0_lit0", 32'(lit_cnt[0]), 32'd63);
    check("lz0_dark", 32'(lit_cnt[1] + lit_cnt[2] + lit_cnt[3]), 32'd0);
    wr(BASE, 32'h0107);
    scan();
    check("lz_inner_d1", 32'(seg_seen[1]), 32'hC0);
    check("lz_inner_lit1", 32'(lit_cnt[1]), 32'd63);
    check("lz_inner_d3", 32'(lit_cnt[3]), 32'd0);
    // raw mode with blank digit 1
    wr(BASE + 2, 32'h803F065B);
    wr(BASE + 1, 32'h10200);
    scan();
    check("raw_d0", 32'(seg_seen[0]), 32'hA4);
    check("raw_blank_d1", 32'(lit_cnt[1]), 32'd0);
    check("raw_d2", 32'(seg_seen[2]), 32'hC0);
    check("raw_d3", 32'(seg_seen[3]), 32'h7F);
    // register width masking
    wr(BASE + 1, 32'hFFFFFFFF); rd(BASE + 1, rv); check("ctrl_mask", rv, 32'h00030F0F);
    wr(BASE, 32'hFFFFFFFF);     rd(BASE, rv);     check("value_mask", rv, 32'h0000FFFF);
    wr(BASE + 3, 32'hFFFFFFFF); rd(BASE + 3, rv); check("raw1_mask", rv, 32'h0);
    wr(BASE + 2, 32'hFFFFFFFF); rd(BASE + 2, rv); check("raw0_rb", rv, 32'hFFFFFFFF);
    wr(BASE + 2, 32'h0);
    // hex mode decimal point
    wr(BASE, 32'h1234);
    wr(BASE + 1, 32'h1);
    scan();
    check("hex_dp_d0", 32'(seg_seen[0]), 32'h19);
    check("hex_nodp_d1", 32'(seg_seen[1]), 32'hB0);
    // brightness
    wr(BASE + 1, 32'h0);
    wr(BASE + 4, 32'h3);
    rd(BASE + 4, rv); check("bright_rb", rv, 32'h3);
    scan();
    for (int k = 0; k < 4; k++) check($sformatf("bright3_d%0d", k), 32'(lit_cnt[k]), 32'd15);
    wr(BASE + 4, 32'hFFFFFFF0);
    rd(BASE + 4, rv); check("bright_mask", rv, 32'h0);
    scan();
    for (int k = 0; k < 4; k++) check($sformatf("bright0_d%0d", k), 32'(lit_cnt[k]), 32'd3);
    wr(BASE + 4, 32'hF);
    // bus qualifiers
    @(negedge clk);
    bus.enable = 1'b0; bus.rw = 1'b1; bus.addr = BASE; wdata = 32'hBEEF; drv = 1'b1;
    @(negedge clk);
    bus.rw = 1'b0; drv = 1'b0;
    rd(BASE, rv); check("no_enable_wr", rv, 32'h1234);
    wr(BASE + 5, 32'hDEAD);
    rd(BASE, rv);     check("base5_value", rv, 32'h1234);
    rd(BASE + 4, rv); check("base5_bright", rv, 32'hF);
    rd(BASE + 5, rv); check("base5_z", rv, 32'hFFFFFFFF);
    rd(BASE - 1, rv); check("below_base_z", rv, 32'hFFFFFFFF);
    @(negedge clk);
    bus.addr = BASE; bus.rw = 1'b0; bus.enable = 1'b0;
    #1 check("disabled_z", data, 32'hFFFFFFFF);
    // reset mid-slot of digit 2
    n = 0;
    while (an != 4'b1011 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("digit2_seen", 32'(an), 32'hB);
    #2 reset_n = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'hFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (an != 4'hF) break;
    end
    check("restart_an", 32'(an), 32'hE);
    check("restart_cycles", 32'(n), 32'd2);
    rd(BASE, rv); check("post_reset_value", rv, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
